// File: rtl/ct_loader_pkg.sv
// ct_loader shared types and constants.
// FSM state encoding and seven-segment display codes.
package ct_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CAPTURE,
        S_REPORT
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [23:0] KEY_NONE = 24'hFFFFFF;

endpackage

// File: rtl/hex_seg7.sv
// Nibble to active-low seven-segment glyph.
// Bit order {g,f,e,d,c,b,a}; glyphs 0-9, A, b, C, d, E, F.
module hex_seg7 (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Glyph lookup
    always_comb begin
        seg = 7'h7F;
        unique case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/ct_loader.sv
// Length-prefixed CT stream loader and doublecrack front end.
// Fills CT memory, runs one crack, shows the key on six digits.
module ct_loader #(
    parameter int START_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic [7:0]  ct_addr,
    output logic [7:0]  ct_wrdata,
    output logic        ct_wren,
    output logic        crack_en,
    input  logic        crack_rdy,
    input  logic [23:0] crack_key,
    input  logic        crack_key_valid,
    output logic [23:0] key_out,
    output logic        key_found,
    output logic        done,
    output logic        err,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    import ct_loader_pkg::*;

    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

    state_t        state;
    logic [8:0]    cnt;
    logic [7:0]    len;
    logic [TW-1:0] tmo;
    logic          hs;
    logic [6:0]    glyph [6];
    logic [6:0]    hex_q [6];

    assign hs = s_valid && s_ready;

    for (genvar i = 0; i < 6; i++) begin : g_dig
        hex_seg7 u_seg (
            .nib (key_out[4*i +: 4]),
            .seg (glyph[i])
        );
    end

    // Control FSM, registered CT write port and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            s_ready   <= 1'b0;
            ct_wren   <= 1'b0;
            ct_addr   <= 8'd0;
            ct_wrdata <= 8'd0;
            crack_en  <= 1'b0;
            cnt       <= 9'd0;
            len       <= 8'd0;
            tmo       <= '0;
            key_out   <= KEY_NONE;
            key_found <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            ct_wren  <= hs;
            crack_en <= 1'b0;
            if (hs) begin
                ct_addr   <= (state == S_IDLE) ? 8'd0 : cnt[7:0];
                ct_wrdata <= s_data;
            end
            unique case (state)
                S_IDLE: begin
                    s_ready <= 1'b1;
                    if (hs) begin
                        len       <= s_data;
                        cnt       <= 9'd1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        key_found <= 1'b0;
                        key_out   <= KEY_NONE;
                        if (s_data == 8'd0) begin
                            s_ready <= 1'b0;
                            state   <= S_REPORT;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        cnt <= cnt + 9'd1;
                        if (cnt == {1'b0, len}) begin
                            s_ready <= 1'b0;
                            state   <= S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (crack_rdy && !ct_wren) begin
                        crack_en <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    tmo   <= '0;
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!crack_rdy) begin
                        state <= S_WAIT_DONE;
                    end else if (tmo == TMO_LAST) begin
                        err       <= 1'b1;
                        key_found <= 1'b0;
                        state     <= S_REPORT;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (crack_rdy) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    key_out   <= crack_key_valid ? crack_key : KEY_NONE;
                    key_found <= crack_key_valid;
                    state     <= S_REPORT;
                end
                S_REPORT: begin
                    done    <= 1'b1;
                    s_ready <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Display register: blank, key glyphs or dashes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= SEG_BLANK;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (!done) begin
                    hex_q[i] <= SEG_BLANK;
                end else if (key_found) begin
                    hex_q[i] <= glyph[i];
                end else begin
                    hex_q[i] <= SEG_DASH;
                end
            end
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule

// File: tb/tb_ct_loader.sv
// Scoreboard bench for ct_loader.
// Stimulus queues expected writes/results; a monitor pops and compares.
module tb_ct_loader;

    localparam int TMO = 16;
    localparam logic [41:0] DASH6  = {6{7'b0111111}};
    localparam logic [41:0] BLANK6 = {6{7'h7F}};

    typedef struct packed {
        logic [23:0] key;
        logic        found;
        logic        err;
        logic [41:0] hx;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic [7:0]  ct_addr;
    logic [7:0]  ct_wrdata;
    logic        ct_wren;
    logic        crack_en;
    logic        crack_rdy = 1'b1;
    logic [23:0] crack_key = 24'h0;
    logic        crack_key_valid = 1'b0;
    logic [23:0] key_out;
    logic        key_found;
    logic        done;
    logic        err;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int en_cnt = 0;
    int en_cyc = 0;
    int err_lat = -1;

    logic [15:0] wr_q [$];
    res_t        res_q [$];

    int          m_mode = 0;
    int          m_lat = 10;
    logic [23:0] m_key = 24'h0;
    logic        m_valid = 1'b0;
    int          busy_cnt = 0;

    ct_loader #(.START_TIMEOUT(TMO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .ct_addr         (ct_addr),
        .ct_wrdata       (ct_wrdata),
        .ct_wren         (ct_wren),
        .crack_en        (crack_en),
        .crack_rdy       (crack_rdy),
        .crack_key       (crack_key),
        .crack_key_valid (crack_key_valid),
        .key_out         (key_out),
        .key_found       (key_found),
        .done            (done),
        .err             (err),
        .hex0            (hex0),
        .hex1            (hex1),
        .hex2            (hex2),
        .hex3            (hex3),
        .hex4            (hex4),
        .hex5            (hex5)
    );

    always #5 clk = ~clk;

    // doublecrack model: mode 0 runs for m_lat cycles, mode 1 ignores en
    always @(posedge clk) begin
        if (crack_en && m_mode == 0) begin
            crack_rdy       <= 1'b0;
            crack_key_valid <= 1'b0;
            busy_cnt        <= m_lat;
        end else if (!crack_rdy) begin
            if (busy_cnt <= 1) begin
                crack_rdy       <= 1'b1;
                crack_key       <= m_key;
                crack_key_valid <= m_valid;
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor
    initial begin
        logic        done_d;
        logic        err_d;
        logic        hex_pend;
        logic [41:0] exp_hx;
        logic [41:0] hexv;
        logic [15:0] ew;
        res_t        r;
        done_d = 1'b0;
        err_d = 1'b0;
        hex_pend = 1'b0;
        exp_hx = '0;
        forever begin
            @(negedge clk);
            hexv = {hex5, hex4, hex3, hex2, hex1, hex0};
            if (!rst_n) begin
                hex_pend = 1'b0;
            end else begin
                if (ct_wren) begin
                    checks++;
                    if (wr_q.size() == 0) begin
                        errors++;
                        $display("FAIL ct_write unexpected addr=%0h data=%0h", ct_addr, ct_wrdata);
                    end else begin
                        ew = wr_q.pop_front();
                        if ({ct_addr, ct_wrdata} !== ew) begin
                            errors++;
                            $display("FAIL ct_write got addr=%0h data=%0h expected addr=%0h data=%0h",
                                     ct_addr, ct_wrdata, ew[15:8], ew[7:0]);
                        end
                    end
                end
                if (hex_pend) begin
                    hex_pend = 1'b0;
                    checks++;
                    if (hexv !== exp_hx) begin
                        errors++;
                        $display("FAIL hex got=%h expected=%h", hexv, exp_hx);
                    end
                end
                if (done && !done_d) begin
                    checks++;
                    if (res_q.size() == 0) begin
                        errors++;
                        $display("FAIL result unexpected done key=%h", key_out);
                    end else begin
                        r = res_q.pop_front();
                        if ({key_out, key_found, err} !== {r.key, r.found, r.err}) begin
                            errors++;
                            $display("FAIL result got key=%h found=%b err=%b expected key=%h found=%b err=%b",
                                     key_out, key_found, err, r.key, r.found, r.err);
                        end
                        exp_hx = r.hx;
                        hex_pend = 1'b1;
                    end
                end
                if (crack_en) begin
                    checks++;
                    if (!crack_rdy) begin
                        errors++;
                        $display("FAIL crack_en_while_busy got rdy=0 expected rdy=1");
                    end
                end
            end
            if (crack_en) begin
                en_cnt++;
                en_cyc = cyc;
            end
            if (err && !err_d) err_lat = cyc - en_cyc;
            done_d = done;
            err_d = err;
        end
    end

    task automatic send(input logic [7:0] b);
        int   n;
        logic acc;
        n = 0;
        s_valid = 1'b1;
        s_data = b;
        while (1) begin
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 400) begin
                checks++;
                errors++;
                $display("FAIL send_timeout byte=%0h got no s_ready expected accept", b);
                break;
            end
        end
        s_valid = 1'b0;
        s_data = 8'h5A;
    endtask

    task automatic wait_done(input int max, output bit rdy_low);
        int n;
        n = 0;
        rdy_low = 1'b1;
        while (!done && n < max) begin
            if (s_ready) rdy_low = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout got done=0 after %0d cycles expected done=1", n);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_reset(input string name);
        check(name,
              {s_ready, ct_wren, ct_addr, ct_wrdata, crack_en, key_out,
               key_found, done, err, hex5, hex4, hex3, hex2, hex1, hex0},
              {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 24'hFFFFFF,
               1'b0, 1'b0, 1'b0, BLANK6});
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        wr_q.delete();
        res_q.delete();
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e0;
        int          c0;
        int          n;
        bit          rl;
        logic [7:0]  d;
        logic [7:0]  msg [4];
        msg = '{8'h03, 8'hA1, 8'hB2, 8'hC3};

        #2;
        rst_n = 1'b0;
        #1;
        check_reset("reset_initial");
        release_reset();

        // 1: key found
        m_mode = 0; m_lat = 100; m_key = 24'h001234; m_valid = 1'b1;
        for (int i = 0; i < 4; i++) push_wr(8'(i), msg[i]);
        res_q.push_back('{24'h001234, 1'b1, 1'b0,
                          {7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19}});
        e0 = en_cnt;
        c0 = cyc;
        for (int i = 0; i < 4; i++) send(msg[i]);
        check("b2b_cycles", 128'(cyc - c0), 128'd4);
        wait_done(400, rl);
        check("en_pulses_t1", 128'(en_cnt - e0), 128'd1);

        // 2: key not found
        m_lat = 20; m_key = 24'h00ABCD; m_valid = 1'b0;
        for (int i = 0; i < 4; i++) push_wr(8'(i), msg[i]);
        res_q.push_back('{24'hFFFFFF, 1'b0, 1'b0, DASH6});
        e0 = en_cnt;
        for (int i = 0; i < 4; i++) send(msg[i]);
        wait_done(400, rl);
        check("en_pulses_t2", 128'(en_cnt - e0), 128'd1);

        // 3: zero length
        push_wr(8'h00, 8'h00);
        res_q.push_back('{24'hFFFFFF, 1'b0, 1'b0, DASH6});
        e0 = en_cnt;
        send(8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("zero_len_done", {done, key_found}, 2'b10);
        repeat (4) @(posedge clk);
        #1;
        check("en_pulses_zero", 128'(en_cnt - e0), 128'd0);

        // 4: start timeout
        m_mode = 1;
        push_wr(8'd0, 8'd2); push_wr(8'd1, 8'h11); push_wr(8'd2, 8'h22);
        res_q.push_back('{24'hFFFFFF, 1'b0, 1'b1, DASH6});
        e0 = en_cnt;
        err_lat = -1;
        send(8'd2); send(8'h11); send(8'h22);
        wait_done(200, rl);
        check("timeout_latency", 128'(err_lat), 128'(TMO + 1));
        check("en_pulses_tmo", 128'(en_cnt - e0), 128'd1);
        m_mode = 0;

        // 5: L=255 with gaps
        m_lat = 10; m_key = 24'hABCDEF; m_valid = 1'b1;
        push_wr(8'd0, 8'hFF);
        for (int i = 1; i < 256; i++) push_wr(8'(i), 8'(i * 7));
        res_q.push_back('{24'hABCDEF, 1'b1, 1'b0,
                          {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}});
        send(8'hFF);
        for (int i = 1; i < 256; i++) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
            d = 8'(i * 7);
            send(d);
        end
        wait_done(200, rl);
        check("ready_low_after_last", 128'(rl), 128'd1);
        check("ready_back_idle", 128'(s_ready), 128'd1);
        check("wr_q_empty_255", 128'(wr_q.size()), 128'd0);

        // 6a: reset mid-LOAD then normal message
        push_wr(8'd0, 8'd5); push_wr(8'd1, 8'd1); push_wr(8'd2, 8'd2);
        send(8'd5); send(8'd1); send(8'd2);
        do_reset();
        check_reset("reset_mid_load");
        release_reset();
        m_lat = 30; m_key = 24'h000C0D; m_valid = 1'b1;
        push_wr(8'd0, 8'd1); push_wr(8'd1, 8'h77);
        res_q.push_back('{24'h000C0D, 1'b1, 1'b0,
                          {7'h40, 7'h40, 7'h40, 7'h46, 7'h40, 7'h21}});
        send(8'd1); send(8'h77);
        wait_done(300, rl);

        // 6b: reset mid-WAIT_DONE; next message waits for busy crack
        m_lat = 100; m_key = 24'h000C0D;
        push_wr(8'd0, 8'd2); push_wr(8'd1, 8'd1); push_wr(8'd2, 8'd2);
        send(8'd2); send(8'd1); send(8'd2);
        n = 0;
        while (crack_rdy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("crack_went_busy", 128'(crack_rdy), 128'd0);
        repeat (10) @(posedge clk);
        do_reset();
        check_reset("reset_mid_wait_done");
        release_reset();
        e0 = en_cnt;
        push_wr(8'd0, 8'd1); push_wr(8'd1, 8'h99);
        res_q.push_back('{24'h000C0D, 1'b1, 1'b0,
                          {7'h40, 7'h40, 7'h40, 7'h46, 7'h40, 7'h21}});
        send(8'd1); send(8'h99);
        wait_done(400, rl);
        check("en_pulses_after_rst", 128'(en_cnt - e0), 128'd1);

        check("wr_q_empty_end", 128'(wr_q.size()), 128'd0);
        check("res_q_empty_end", 128'(res_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
